// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_enable_gen
// Description : Multi-channel fractional clock-enable generator running on the
//               PLL output clock. Synchronises and filters PLL_LOCKED, sequences
//               a synchronous downstream reset (RST_OUT) and, once running,
//               produces CHANNELS one-cycle CE strobes from phase accumulators
//               whose increments can be reloaded at run time through a
//               valid/ready handshake.
//               Optional feature macro: LOCK_LOSS_COUNT_EN adds LOSS_CNT[7:0],
//               a saturating count of RUN -> WAIT_LOCK transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_enable_gen #(
    parameter int                         CHANNELS  = 2,
    parameter int                         ACC_W     = 16,
    parameter logic [CHANNELS*ACC_W-1:0]  INC_INIT  = {16'h4000, 16'h8000},
    parameter int                         LOCK_FILT = 1024,
    parameter int                         RST_HOLD  = 16
) (
    input  logic                 CLK_IN1,
    input  logic                 RESET,
    input  logic                 PLL_LOCKED,
    input  logic                 LOAD_VALID,
    output logic                 LOAD_READY,
    input  logic [2:0]           LOAD_CH,
    input  logic [ACC_W-1:0]     LOAD_INC,
    output logic [CHANNELS-1:0]  CE,
    output logic                 RST_OUT,
    output logic                 READY
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]           LOSS_CNT
`endif
);

    // One shared counter serves both the lock filter and the reset hold.
    localparam int C_CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam logic [C_CNT_W-1:0] C_FILT_LAST = C_CNT_W'(LOCK_FILT - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(RST_HOLD - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_FILTER    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       lock_s;

    // Shift the raw lock into the two-stage synchroniser.
    always_comb begin
        sync_d = {sync_q[0], PLL_LOCKED};
    end

    // Synchroniser flops; bit 1 is the clean lock seen by the sequencer.
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign lock_s = sync_q[1];

    // ------------------------------------------------------------------
    // Lock supervision / reset sequencer
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;
    logic               rst_out_q;
    logic               rst_out_d;
    logic               ready_q;
    logic               ready_d;
    logic               run_q;
    logic               stay_run;

    // Next state: any loss of lock restarts the whole qualification.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d = ST_FILTER;
                    cnt_d   = '0;
                end
                ST_FILTER: begin
                    if (cnt_q == C_FILT_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == C_HOLD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs are registered from the next state so they change on the
        // same edge the sequencer enters or leaves RUN.
        rst_out_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
    end

    // Sequencer state, counter and its registered outputs.
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    assign run_q    = (state_q == ST_RUN);
    // Accumulate only on edges that keep us in RUN, so CE drops on the very
    // edge that leaves RUN.
    assign stay_run = run_q && (state_d == ST_RUN);

    // ------------------------------------------------------------------
    // Phase accumulators and increment reload
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0][ACC_W-1:0] acc_q;
    logic [CHANNELS-1:0][ACC_W-1:0] acc_d;
    logic [CHANNELS-1:0][ACC_W-1:0] inc_q;
    logic [CHANNELS-1:0][ACC_W-1:0] inc_d;
    logic [CHANNELS-1:0][ACC_W-1:0] stg_q;
    logic [CHANNELS-1:0][ACC_W-1:0] stg_d;
    logic [CHANNELS-1:0][ACC_W-1:0] acc_sum;
    logic [CHANNELS-1:0]            carry;
    logic [CHANNELS-1:0]            pending_q;
    logic [CHANNELS-1:0]            pending_d;
    logic [CHANNELS-1:0]            ce_q;
    logic [CHANNELS-1:0]            ce_d;
    logic                           load_ready;
    logic                           load_xfer;

    // Ready reflects the addressed channel; out-of-range channels always
    // accept and the data is dropped.
    always_comb begin
        load_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (LOAD_CH == 3'(i)) begin
                load_ready = ~pending_q[i];
            end
        end
    end

    assign load_xfer = LOAD_VALID && load_ready;

    // Per-channel add, strobe generation and staged-increment hand-over.
    always_comb begin
        acc_d     = acc_q;
        inc_d     = inc_q;
        stg_d     = stg_q;
        pending_d = pending_q;
        ce_d      = '0;
        acc_sum   = '0;
        carry     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            {carry[i], acc_sum[i]} = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            if (stay_run) begin
                acc_d[i] = acc_sum[i];
                ce_d[i]  = carry[i];
            end else begin
                acc_d[i] = '0;
            end
            // In RUN a new rate takes effect only at a period boundary;
            // otherwise there is no phase to protect and it applies at once.
            if (pending_q[i] && (!run_q || carry[i])) begin
                inc_d[i]     = stg_q[i];
                pending_d[i] = 1'b0;
            end else if (load_xfer && (LOAD_CH == 3'(i))) begin
                stg_d[i]     = LOAD_INC;
                pending_d[i] = 1'b1;
            end
        end
    end

    // Channel state registers; increments restart from their initial values.
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            acc_q     <= '0;
            inc_q     <= INC_INIT;
            stg_q     <= '0;
            pending_q <= '0;
            ce_q      <= '0;
        end else begin
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            stg_q     <= stg_d;
            pending_q <= pending_d;
            ce_q      <= ce_d;
        end
    end

    assign LOAD_READY = load_ready;
    assign CE         = ce_q;
    assign RST_OUT    = rst_out_q;
    assign READY      = ready_q;

`ifdef LOCK_LOSS_COUNT_EN
    // ------------------------------------------------------------------
    // Lock-loss counter
    // ------------------------------------------------------------------
    logic [7:0] loss_cnt_q;
    logic [7:0] loss_cnt_d;

    // Count each exit from RUN caused by lock loss, saturating at 255.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (run_q && (state_d == ST_WAIT_LOCK) && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // Counter register; only RESET clears it.
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign LOSS_CNT = loss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_enable_gen
// Description : Self-checking bench for clk_enable_gen with a behavioural
//               reference model (lock streak length, integer phase arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_enable_gen;

    localparam int   CH        = 2;
    localparam int   AW        = 16;
    localparam int   LOCK_FILT = 1024;
    localparam int   RST_HOLD  = 16;
    localparam int   RISE_LAT  = 1043;
    localparam int   L_RUN     = 1 + LOCK_FILT + RST_HOLD;
    localparam longint MODV    = longint'(1) << AW;

    logic          clk;
    logic          RESET;
    logic          PLL_LOCKED;
    logic          LOAD_VALID;
    logic          LOAD_READY;
    logic [2:0]    LOAD_CH;
    logic [AW-1:0] LOAD_INC;
    logic [CH-1:0] CE;
    logic          RST_OUT;
    logic          READY;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0]    LOSS_CNT;
`endif

    int tests = 0;
    int fails = 0;

    clk_enable_gen #(
        .CHANNELS  (CH),
        .ACC_W     (AW),
        .INC_INIT  ({16'h4000, 16'h8000}),
        .LOCK_FILT (LOCK_FILT),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .CLK_IN1    (clk),
        .RESET      (RESET),
        .PLL_LOCKED (PLL_LOCKED),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .LOAD_CH    (LOAD_CH),
        .LOAD_INC   (LOAD_INC),
        .CE         (CE),
        .RST_OUT    (RST_OUT),
        .READY      (READY)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .LOSS_CNT   (LOSS_CNT)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    bit      d1, d2;
    int      streak;
    bit      m_run;
    int      m_loss;
    longint  ph  [CH];
    longint  inc [CH];
    longint  stg [CH];
    bit      pend[CH];
    bit [CH-1:0] m_ce;

    function automatic void model_reset();
        d1 = 0; d2 = 0; streak = 0; m_run = 0; m_loss = 0; m_ce = '0;
        for (int c = 0; c < CH; c++) begin
            ph[c] = 0; stg[c] = 0; pend[c] = 0;
        end
        inc[0] = 64'h8000;
        inc[1] = 64'h4000;
    endfunction

    function automatic bit ready_for(input logic [2:0] ch);
        if (int'(ch) >= CH) return 1'b1;
        return !pend[int'(ch)];
    endfunction

    // Advance the model by one edge using the inputs present before it.
    function automatic void model_edge();
        bit ls, was, ok, cy;
        if (RESET) begin
            model_reset();
            return;
        end
        ok = LOAD_VALID && ready_for(LOAD_CH);
        ls = d2; d2 = d1; d1 = PLL_LOCKED;
        was = m_run;
        streak = ls ? ((streak < L_RUN) ? streak + 1 : streak) : 0;
        m_run = (streak >= L_RUN);
        if (was && !m_run && m_loss < 255) m_loss++;
        for (int c = 0; c < CH; c++) begin
            cy = (ph[c] + inc[c]) >= MODV;
            if (was && m_run) begin
                m_ce[c] = cy;
                ph[c]   = (ph[c] + inc[c]) % MODV;
            end else begin
                m_ce[c] = 1'b0;
                ph[c]   = 0;
            end
            if (pend[c] && (!was || cy)) begin
                inc[c]  = stg[c];
                pend[c] = 1'b0;
            end else if (ok && int'(LOAD_CH) == c) begin
                stg[c]  = longint'(LOAD_INC);
                pend[c] = 1'b1;
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("ce",         32'(CE),         32'(m_ce));
        check("ready",      32'(READY),      32'(m_run));
        check("rst_out",    32'(RST_OUT),    32'(!m_run));
        check("load_ready", 32'(LOAD_READY), 32'(ready_for(LOAD_CH)));
`ifdef LOCK_LOSS_COUNT_EN
        check("loss_cnt",   32'(LOSS_CNT),   32'(m_loss));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic load(input logic [2:0] ch, input logic [AW-1:0] v);
        LOAD_VALID = 1'b1; LOAD_CH = ch; LOAD_INC = v;
        step();
        LOAD_VALID = 1'b0;
    endtask

    // Count edges until READY rises; returns the edge number (0 on timeout).
    task automatic wait_ready(output int n_at, output bit rst_low);
        n_at = 0; rst_low = 1'b0;
        for (int n = 1; n <= 1500; n++) begin
            step();
            if (READY === 1'b1) begin
                n_at = n;
                break;
            end
            if (RST_OUT !== 1'b1) rst_low = 1'b1;
        end
    endtask

    // With the initial increments: first CE0 two edges after READY, then
    // CE0 every 2nd and CE1 every 4th edge.
    task automatic ce_pattern(input string tag);
        int n0, n1;
        step();
        check({tag, "_ce0_lat1"}, 32'(CE[0]), 32'd0);
        step();
        check({tag, "_ce0_lat2"}, 32'(CE[0]), 32'd1);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            n0 += int'(CE[0]);
            n1 += int'(CE[1]);
        end
        check({tag, "_ce0_count16"}, 32'(n0), 32'd8);
        check({tag, "_ce1_count16"}, 32'(n1), 32'd4);
    endtask

    // ---------------- directed / random sequence ----------------
    initial begin
        int  n_at, last, npul, ch, r, idle;
        bit  rst_low;
        logic [AW-1:0] v;

        RESET = 1'b1; PLL_LOCKED = 1'b0; LOAD_VALID = 1'b0;
        LOAD_CH = 3'd0; LOAD_INC = '0;
        model_reset();

        // Reset state.
        for (int k = 0; k < 3; k++) step();
        check("reset_ce", 32'(CE), 32'd0);
        check("reset_rst_out", 32'(RST_OUT), 32'd1);

        // Lock present from the first edge after reset release.
        RESET = 1'b0; PLL_LOCKED = 1'b1;
        wait_ready(n_at, rst_low);
        check("ready_rise_edge", 32'(n_at), 32'(RISE_LAT));
        ce_pattern("run0");

        // Mid-period reload of ch0: period must become exactly 8, no short one.
        load(3'd0, 16'h2000);
        check("ld_ready_ch0_pending", 32'(LOAD_READY), 32'd0);
        last = -1; npul = 0;
        for (int s = 1; s <= 48; s++) begin
            step();
            if (CE[0] === 1'b1) begin
                if (last >= 0) check("ce0_period8", 32'(s - last), 32'd8);
                last = s;
                npul++;
            end
        end
        check("ce0_pulses_ge5", 32'(npul >= 5), 32'd1);

        // Randomised reloads, including zero and maximum increments.
        for (int it = 0; it < 30; it++) begin
            ch = int'($urandom_range(0, 3));
            if (ch < CH && pend[ch]) ch = ch + 2;
            r = int'($urandom_range(0, 9));
            if (r == 0)      v = '0;
            else if (r == 1) v = 16'hFFFF;
            else             v = AW'($urandom_range(16'h1000, 16'hFFFF));
            load(3'(ch), v);
            idle = int'($urandom_range(0, 20));
            for (int k = 0; k < idle; k++) begin
                LOAD_CH = 3'($urandom_range(0, 7));
                step();
            end
        end

        // Lock loss in RUN.
        LOAD_CH = 3'd0;
        PLL_LOCKED = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("loss_ready", 32'(READY), 32'd0);
        check("loss_rst_out", 32'(RST_OUT), 32'd1);
        check("loss_ce", 32'(CE), 32'd0);
`ifdef LOCK_LOSS_COUNT_EN
        check("loss_cnt_one", 32'(LOSS_CNT), 32'd1);
`endif
        for (int k = 0; k < 5; k++) step();

        // One-cycle glitch while filtering at count 500 forces a full recount.
        PLL_LOCKED = 1'b1;
        rst_low = 1'b0;
        for (int k = 0; k < 501; k++) begin
            step();
            if (RST_OUT !== 1'b1) rst_low = 1'b1;
        end
        PLL_LOCKED = 1'b0;
        step();
        PLL_LOCKED = 1'b1;
        check("glitch_rst_held_a", 32'(rst_low), 32'd0);
        wait_ready(n_at, rst_low);
        check("glitch_recount", 32'(n_at), 32'(RISE_LAT));
        check("glitch_rst_held_b", 32'(rst_low), 32'd0);

        // Reset pulse in RUN with a staged load outstanding.
        for (int k = 0; k < 3; k++) step();
        load(3'd1, 16'h1000);
        check("pend_before_reset", 32'(LOAD_READY), 32'd0);
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        check("arst_ce", 32'(CE), 32'd0);
        check("arst_ready", 32'(READY), 32'd0);
        check("arst_rst_out", 32'(RST_OUT), 32'd1);
        check("arst_load_ready", 32'(LOAD_READY), 32'd1);
`ifdef LOCK_LOSS_COUNT_EN
        check("arst_loss_cnt", 32'(LOSS_CNT), 32'd0);
`endif
        for (int k = 0; k < 2; k++) step();
        RESET = 1'b0;
        wait_ready(n_at, rst_low);
        check("rerun_ready_rise", 32'(n_at), 32'(RISE_LAT));
        ce_pattern("run1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
